// File: rtl/reorder_buffer.sv
// Circular reorder buffer: captures FU results, broadcasts ready values, retires in order, flushes on taken BGE.
// Latency: writeback at edge N can retire at edge N+1; alloc_ok drops when full or while a flush retires.
module reorder_buffer #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 4,
  parameter int FU_NUM    = 4,
  parameter int REG_INDEX = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_req,
  input  logic [REG_INDEX-1:0]          alloc_dest_reg,
  input  logic                          alloc_is_branch,
  input  logic [WORD_SIZE-1:0]          alloc_target,
  output logic                          alloc_ok,
  output logic [RB_INDEX-1:0]           alloc_index,
  input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
  input  logic [FU_NUM-1:0]             valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
  output logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
  output logic [RB_SIZE-1:0]            CDB_data_valid,
  output logic [FU_NUM-1:0]             reset_bus,
  output logic                          commit_valid,
  output logic [REG_INDEX-1:0]          commit_reg,
  output logic [WORD_SIZE-1:0]          commit_data,
  output logic                          flush,
  output logic [WORD_SIZE-1:0]          redirect_pc
);

  localparam int PTR_W = $clog2(RB_SIZE);
  localparam logic [RB_INDEX-1:0] NULL_IDX = '1;

  typedef struct packed {
    logic                 busy;
    logic                 ready;
    logic                 is_branch;
    logic [REG_INDEX-1:0] dest_reg;
    logic [WORD_SIZE-1:0] value;
    logic [WORD_SIZE-1:0] target;
  } rb_entry_t;

  rb_entry_t            ent [RB_SIZE];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [PTR_W:0]       count;

  logic                 head_done;
  logic                 take_flush;
  logic                 retire;
  logic                 alloc_fire;
  logic [RB_INDEX-1:0]  wb_idx [FU_NUM];
  logic [RB_SIZE-1:0]   wb_hit;
  logic [WORD_SIZE-1:0] wb_val [RB_SIZE];

  assign head_done  = ent[head].busy & ent[head].ready;
  assign take_flush = head_done & ent[head].is_branch & ent[head].value[0];
  assign retire     = head_done & ~take_flush;

  assign alloc_ok    = (count < (PTR_W+1)'(RB_SIZE)) & ~take_flush;
  assign alloc_fire  = alloc_req & alloc_ok;
  assign alloc_index = RB_INDEX'(tail);

  always_comb begin
    for (int f = 0; f < FU_NUM; f++) begin
      wb_idx[f] = RB_index_bus[f*RB_INDEX +: RB_INDEX];
    end
  end

  // Scan from the highest FU down so the lowest-numbered FU overwrites last and wins.
  always_comb begin
    wb_hit = '0;
    for (int i = 0; i < RB_SIZE; i++) begin
      wb_val[i] = '0;
    end
    for (int f = FU_NUM-1; f >= 0; f--) begin
      if (valid_bus[f] && (wb_idx[f] != NULL_IDX) && ((wb_idx[f] >> PTR_W) == '0)
          && ent[wb_idx[f][PTR_W-1:0]].busy) begin
        wb_hit[wb_idx[f][PTR_W-1:0]] = 1'b1;
        wb_val[wb_idx[f][PTR_W-1:0]] = data_bus[f*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_comb begin
    CDB_data_data  = '0;
    CDB_data_valid = '0;
    for (int i = 0; i < RB_SIZE; i++) begin
      CDB_data_data[i*WORD_SIZE +: WORD_SIZE] = ent[i].value;
      CDB_data_valid[i]                       = ent[i].busy & ent[i].ready;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RB_SIZE; i++) begin
        ent[i] <= '0;
      end
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_reg   <= '0;
      commit_data  <= '0;
      flush        <= 1'b0;
      redirect_pc  <= '0;
      reset_bus    <= '1;
    end else begin
      commit_valid <= 1'b0;
      flush        <= 1'b0;
      reset_bus    <= '0;
      if (take_flush) begin
        // Taken branch: drop every in-flight entry and same-cycle alloc/writeback, kick all FUs.
        for (int i = 0; i < RB_SIZE; i++) begin
          ent[i].busy  <= 1'b0;
          ent[i].ready <= 1'b0;
        end
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        flush       <= 1'b1;
        redirect_pc <= ent[head].target;
        reset_bus   <= '1;
      end else begin
        for (int i = 0; i < RB_SIZE; i++) begin
          if (wb_hit[i]) begin
            ent[i].value <= wb_val[i];
            ent[i].ready <= 1'b1;
          end
        end
        if (alloc_fire) begin
          ent[tail].busy      <= 1'b1;
          ent[tail].ready     <= 1'b0;
          ent[tail].is_branch <= alloc_is_branch;
          ent[tail].dest_reg  <= alloc_dest_reg;
          ent[tail].value     <= '0;
          ent[tail].target    <= alloc_target;
          tail                <= tail + PTR_W'(1);
        end
        // Not-taken branches retire silently; only register writes raise commit_valid.
        if (retire) begin
          ent[head].busy  <= 1'b0;
          ent[head].ready <= 1'b0;
          head            <= head + PTR_W'(1);
          if (!ent[head].is_branch) begin
            commit_valid <= 1'b1;
            commit_reg   <= ent[head].dest_reg;
            commit_data  <= ent[head].value;
          end
        end
        count <= count + (PTR_W+1)'(alloc_fire) - (PTR_W+1)'(retire);
      end
    end
  end

endmodule
